// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_pkg
// Brief    : Shared types and default timing constants for the key conditioner
// Revision : 1.0 - initial release
// ============================================================================
package key_pkg;

   // Per-channel debounce FSM state
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DB_PRESS = 3'd1,
      HELD     = 3'd2,
      LONG     = 3'd3,
      DB_REL   = 3'd4
   } kstate_t;

   // 20 ms debounce and 1 s long-press at 50 MHz
   localparam int DB_CYCLES_DEF   = 1000000;
   localparam int HOLD_CYCLES_DEF = 50000000;

endpackage : key_pkg
`default_nettype wire

// File: rtl/key_db_chan.sv
`default_nettype none
// ============================================================================
// Module   : key_db_chan
// Brief    : One button channel: 2-flop synchronizer, debounce FSM with
//            debounce/hold counters, registered level and event pulses
// Revision : 1.0 - initial release
// ============================================================================
module key_db_chan
   import key_pkg::*;
#(
   parameter int DB_CYCLES   = DB_CYCLES_DEF,
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
   parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
   input  logic clk,
   input  logic CLRN,
   input  logic key_n,          // raw button, 0 = pressed
   output logic level,
   output logic press,
   output logic release_pulse,  // 'release' is a reserved word
   output logic long_press
);

   localparam int                c_DB_W      = $clog2(DB_CYCLES + 1);
   localparam logic [c_DB_W-1:0] c_DB_LAST   = c_DB_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0]  c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   logic [1:0]        r_sync;
   logic              w_sp;
   kstate_t           r_state,     w_state_nxt;
   logic [c_DB_W-1:0] r_db_cnt,    w_db_cnt_nxt;
   logic [CNT_W-1:0]  r_hold_cnt,  w_hold_cnt_nxt;
   logic              r_from_long, w_from_long_nxt;
   logic              r_lvl,       w_lvl_nxt;
   logic              r_press_evt, w_press_evt;
   logic              r_rel_evt,   w_rel_evt;
   logic              r_long_evt,  w_long_evt;

   // Two-flop synchronizer; resets to the released level
   always_ff @(posedge clk or negedge CLRN) begin
      if (!CLRN) r_sync <= 2'b11;
      else       r_sync <= {r_sync[0], key_n};
   end

   assign w_sp = ~r_sync[1];

   // FSM state, counters and event flags
   always_ff @(posedge clk or negedge CLRN) begin
      if (!CLRN) begin
         r_state     <= IDLE;
         r_db_cnt    <= '0;
         r_hold_cnt  <= '0;
         r_from_long <= 1'b0;
         r_lvl       <= 1'b0;
         r_press_evt <= 1'b0;
         r_rel_evt   <= 1'b0;
         r_long_evt  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_db_cnt    <= w_db_cnt_nxt;
         r_hold_cnt  <= w_hold_cnt_nxt;
         r_from_long <= w_from_long_nxt;
         r_lvl       <= w_lvl_nxt;
         r_press_evt <= w_press_evt;
         r_rel_evt   <= w_rel_evt;
         r_long_evt  <= w_long_evt;
      end
   end

   // Next-state, counter and event decode
   always_comb begin
      w_state_nxt     = r_state;
      w_db_cnt_nxt    = r_db_cnt;
      w_hold_cnt_nxt  = r_hold_cnt;
      w_from_long_nxt = r_from_long;
      w_lvl_nxt       = r_lvl;
      w_press_evt     = 1'b0;
      w_rel_evt       = 1'b0;
      w_long_evt      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_sp) begin
               w_state_nxt  = DB_PRESS;
               w_db_cnt_nxt = '0;
            end
         end
         DB_PRESS: begin
            if (!w_sp) begin
               w_state_nxt = IDLE;
            end else if (r_db_cnt == c_DB_LAST) begin
               w_state_nxt    = HELD;
               w_lvl_nxt      = 1'b1;
               w_press_evt    = 1'b1;
               w_hold_cnt_nxt = '0;
            end else begin
               w_db_cnt_nxt = r_db_cnt + c_DB_W'(1);
            end
         end
         HELD: begin
            if (!w_sp) begin
               w_state_nxt     = DB_REL;
               w_db_cnt_nxt    = '0;
               w_from_long_nxt = 1'b0;
            end else if (r_hold_cnt == c_HOLD_LAST) begin
               w_state_nxt = LONG;
               w_long_evt  = 1'b1;
            end else begin
               w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
            end
         end
         LONG: begin
            if (!w_sp) begin
               w_state_nxt     = DB_REL;
               w_db_cnt_nxt    = '0;
               w_from_long_nxt = 1'b1;
            end
         end
         DB_REL: begin
            // Bounce back to the hold state without any pulse; level stays 1
            if (w_sp) begin
               w_state_nxt = r_from_long ? LONG : HELD;
            end else if (r_db_cnt == c_DB_LAST) begin
               w_state_nxt = IDLE;
               w_lvl_nxt   = 1'b0;
               w_rel_evt   = 1'b1;
            end else begin
               w_db_cnt_nxt = r_db_cnt + c_DB_W'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output register stage: outputs appear DB_CYCLES+3 edges after the first low sample
   always_ff @(posedge clk or negedge CLRN) begin
      if (!CLRN) begin
         level         <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
         long_press    <= 1'b0;
      end else begin
         level         <= r_lvl;
         press         <= r_press_evt;
         release_pulse <= r_rel_evt;
         long_press    <= r_long_evt;
      end
   end

endmodule : key_db_chan
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : key_conditioner
// Brief    : Synchronizes and debounces N_KEYS active-low push buttons and
//            produces level, press, release and long-press indications
// Revision : 1.0 - initial release
// ============================================================================
module key_conditioner
   import key_pkg::*;
#(
   parameter int N_KEYS      = 4,
   parameter int DB_CYCLES   = DB_CYCLES_DEF,
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
   parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
   input  logic              clk,
   input  logic              CLRN,
   input  logic [N_KEYS-1:0] KEY,
   output logic [N_KEYS-1:0] level,
   output logic [N_KEYS-1:0] press,
   output logic [N_KEYS-1:0] release_pulse,
   output logic [N_KEYS-1:0] long_press
);

   // One fully independent conditioning channel per button
   generate
      for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
         key_db_chan #(
            .DB_CYCLES   (DB_CYCLES),
            .HOLD_CYCLES (HOLD_CYCLES),
            .CNT_W       (CNT_W)
         ) u_chan (
            .clk           (clk),
            .CLRN          (CLRN),
            .key_n         (KEY[i]),
            .level         (level[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i]),
            .long_press    (long_press[i])
         );
      end
   endgenerate

endmodule : key_conditioner
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_conditioner
// Brief    : Scoreboard bench for key_conditioner against a run-length model
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_conditioner;

   localparam int N    = 4;
   localparam int DB   = 4;
   localparam int HOLD = 16;

   logic         clk  = 1'b0;
   logic         CLRN = 1'b0;
   logic [N-1:0] KEY  = '1;
   logic [N-1:0] level, press, rel_pulse, long_press;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   key_conditioner #(
      .N_KEYS      (N),
      .DB_CYCLES   (DB),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk           (clk),
      .CLRN          (CLRN),
      .KEY           (KEY),
      .level         (level),
      .press         (press),
      .release_pulse (rel_pulse),
      .long_press    (long_press)
   );

   always #5 clk = ~clk;

   // Expected pulses: cycle tag, key index, kind (0 press, 1 release, 2 long)
   typedef struct {
      int cyc;
      int key;
      int kind;
   } ev_t;
   ev_t evq[$];

   // Reference model: accept a level after DB+1 consecutive equal samples;
   // hold time counts pressed samples that follow another pressed sample.
   logic [N-1:0] s1, s2, down, prev_sp, long_done, lvl_vis;
   int run1 [N];
   int run0 [N];
   int hold [N];

   task automatic model_reset();
      s1 = '1; s2 = '1; down = '0; prev_sp = '0; long_done = '0; lvl_vis = '0;
      for (int k = 0; k < N; k++) begin
         run1[k] = 0; run0[k] = 0; hold[k] = 0;
      end
      evq.delete();
   endtask

   task automatic push_ev(int c, int k, int kind);
      ev_t e;
      e.cyc = c; e.key = k; e.kind = kind;
      evq.push_back(e);
   endtask

   // Model step on every clock edge; raw key reaches the decision two edges later
   always @(posedge clk or negedge CLRN) begin
      if (!CLRN) begin
         model_reset();
      end else begin
         cyc++;
         lvl_vis = down;
         for (int k = 0; k < N; k++) begin
            logic sp;
            sp = ~s2[k];
            if (!down[k]) begin
               run1[k] = sp ? run1[k] + 1 : 0;
               if (run1[k] == DB + 1) begin
                  down[k] = 1'b1; run0[k] = 0; hold[k] = 0; long_done[k] = 1'b0;
                  push_ev(cyc + 1, k, 0);
               end
            end else if (!sp) begin
               run0[k]++;
               if (run0[k] == DB + 1) begin
                  down[k] = 1'b0; run1[k] = 0;
                  push_ev(cyc + 1, k, 1);
               end
            end else begin
               run0[k] = 0;
               if (prev_sp[k]) begin
                  hold[k]++;
                  if (hold[k] == HOLD && !long_done[k]) begin
                     long_done[k] = 1'b1;
                     push_ev(cyc + 1, k, 2);
                  end
               end
            end
            prev_sp[k] = sp;
         end
         s2 = s1;
         s1 = KEY;
      end
   end

   // Monitor: pop expected pulses whenever the DUT shows one; check level every cycle
   always @(negedge clk) begin
      if (!CLRN) begin
         tests++;
         if ({level, press, rel_pulse, long_press} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0", {level, press, rel_pulse, long_press});
         end
      end else begin
         tests++;
         if (level !== lvl_vis) begin
            fails++;
            $display("FAIL level cyc %0d: got %b expected %b", cyc, level, lvl_vis);
         end
         for (int k = 0; k < N; k++) begin
            for (int kind = 0; kind < 3; kind++) begin
               logic b;
               b = (kind == 0) ? press[k] : (kind == 1) ? rel_pulse[k] : long_press[k];
               if (b === 1'b1) begin
                  tests++;
                  if (evq.size() == 0) begin
                     fails++;
                     $display("FAIL unexpected_pulse cyc %0d: got key %0d kind %0d expected none", cyc, k, kind);
                  end else begin
                     ev_t e;
                     e = evq.pop_front();
                     if (e.cyc != cyc || e.key != k || e.kind != kind) begin
                        fails++;
                        $display("FAIL pulse: got cyc %0d key %0d kind %0d expected cyc %0d key %0d kind %0d",
                                 cyc, k, kind, e.cyc, e.key, e.kind);
                     end
                  end
               end
            end
         end
         while (evq.size() > 0 && evq[0].cyc <= cyc) begin
            ev_t e;
            e = evq.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_pulse: got none expected cyc %0d key %0d kind %0d", e.cyc, e.key, e.kind);
         end
      end
   end

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Wait (bounded) for press[k] and check it lands 7 edges after the first low sample
   task automatic check_press_latency(int k, int first_edge, string name);
      int seen;
      seen = -1;
      for (int i = 0; i < 30 && seen < 0; i++) begin
         @(negedge clk);
         if (press[k] === 1'b1) seen = cyc;
      end
      tests++;
      if (seen != first_edge + DB + 3) begin
         fails++;
         $display("FAIL %s: got press at cyc %0d expected cyc %0d", name, seen, first_edge + DB + 3);
      end
   endtask

   initial begin
      int dwell [N];
      int f;

      // 1: reset, then idle keys
      CLRN = 1'b0; KEY = '1;
      repeat (3) @(posedge clk);
      #1 CLRN = 1'b1;
      tick(50);

      // 2: KEY[0] falls and stays low
      KEY[0] = 1'b0;
      f = cyc + 1;
      check_press_latency(0, f, "press0_latency");
      tick(3);

      // 3: short glitches on KEY[1] must be rejected
      for (int w = 1; w <= 3; w++) begin
         KEY[1] = 1'b0; tick(w);
         KEY[1] = 1'b1; tick(5);
      end

      // 4: KEY[2] held 40 cycles, then released
      KEY[2] = 1'b0; tick(40);
      KEY[2] = 1'b1; tick(20);

      // 5: KEY[3] accepted, then 2-cycle release glitches during the hold
      KEY[3] = 1'b0; tick(10);
      repeat (3) begin
         tick(3);
         KEY[3] = 1'b1; tick(2);
         KEY[3] = 1'b0;
      end
      tick(30);
      KEY[3] = 1'b1; tick(15);

      // 6: reset while KEY[0] is held; outputs clear at once, press re-qualifies
      @(posedge clk);
      #1 CLRN = 1'b0;
      #1;
      tests++;
      if ({level, press, rel_pulse, long_press} !== '0) begin
         fails++;
         $display("FAIL async_reset: got %h expected 0", {level, press, rel_pulse, long_press});
      end
      @(posedge clk);
      #1 CLRN = 1'b1;
      f = cyc + 1;
      check_press_latency(0, f, "press0_after_reset");
      tick(5);

      // Random phase: mixed bouncy and steady dwell times, occasional resets
      for (int k = 0; k < N; k++) dwell[k] = $urandom_range(1, 20);
      repeat (1500) begin
         for (int k = 0; k < N; k++) begin
            dwell[k]--;
            if (dwell[k] <= 0) begin
               KEY[k] = ~KEY[k];
               dwell[k] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(5, 40);
            end
         end
         if ($urandom_range(0, 399) == 0) begin
            CLRN = 1'b0;
            tick($urandom_range(1, 2));
            CLRN = 1'b1;
         end
         tick(1);
      end

      // Drain: release everything and let all pending events appear
      KEY = '1;
      tick(40);
      tests++;
      if (evq.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending events expected 0", evq.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_key_conditioner
`default_nettype wire
